// File: rtl/alu_dispatch.sv
// Issue stage for the integer ALU: input FIFO, registered execute stage that
// drives the external combinational ALU, and a writeback register with handshake.
module alu_dispatch #(
  parameter int ALU_OP = 4,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_OP-1:0]        in_op,
  input  logic [31:0]              in_srcA,
  input  logic [31:0]              in_srcB,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [ALU_OP-1:0]        alu_op,
  output logic [31:0]              alu_srcA,
  output logic [31:0]              alu_srcB,
  input  logic [31:0]              alu_result,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [31:0]              wb_data,
  output logic [TAG_W-1:0]         wb_tag,
  output logic                     wb_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ALU_OP-1:0] fifo_op  [DEPTH];
  logic [31:0]       fifo_a   [DEPTH];
  logic [31:0]       fifo_b   [DEPTH];
  logic [TAG_W-1:0]  fifo_tag [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              ex_valid;
  logic [TAG_W-1:0]  ex_tag;
  logic              ex_illegal;

  logic push;
  logic wb_move;
  logic ex_move;
  logic ex_load;
  logic head_illegal;

  // in_ready depends only on registered occupancy (and reset), never on wb_ready
  assign in_ready     = !reset && (count < CW'(DEPTH));
  assign push         = in_valid && in_ready;
  assign wb_move      = !wb_valid || wb_ready;
  assign ex_move      = ex_valid && wb_move;
  assign ex_load      = (count != '0) && (!ex_valid || ex_move);
  assign head_illegal = (fifo_op[rd_ptr] == '0) || (fifo_op[rd_ptr] > ALU_OP'(7));

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_op[wr_ptr]  <= in_op;
      fifo_a[wr_ptr]   <= in_srcA;
      fifo_b[wr_ptr]   <= in_srcB;
      fifo_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (ex_load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, ex_load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Execute stage: ALU inputs idle at zero whenever the stage is empty
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_tag     <= '0;
      ex_illegal <= 1'b0;
      alu_op     <= '0;
      alu_srcA   <= '0;
      alu_srcB   <= '0;
    end else if (ex_load) begin
      ex_valid   <= 1'b1;
      ex_tag     <= fifo_tag[rd_ptr];
      ex_illegal <= head_illegal;
      alu_op     <= fifo_op[rd_ptr];
      alu_srcA   <= fifo_a[rd_ptr];
      alu_srcB   <= fifo_b[rd_ptr];
    end else if (ex_move) begin
      ex_valid   <= 1'b0;
      ex_tag     <= '0;
      ex_illegal <= 1'b0;
      alu_op     <= '0;
      alu_srcA   <= '0;
      alu_srcB   <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_tag     <= '0;
      wb_illegal <= 1'b0;
    end else if (ex_move) begin
      wb_valid   <= 1'b1;
      wb_data    <= alu_result;
      wb_tag     <= ex_tag;
      wb_illegal <= ex_illegal;
    end else if (wb_ready && wb_valid) begin
      wb_valid   <= 1'b0;
    end
  end

endmodule
